rv_mem_arbiter: RTL and testbench
=================================

# rv_mem_arbiter

Two-requester arbiter that shares one single-port unified memory between the core's instruction-fetch port and its data port. It sits between the pipelined core's IMEM/DMEM interfaces and the memory, with one transaction outstanding at a time. Data accesses have fixed priority; a starvation counter guarantees instruction fetch forward progress. The arbiter sequences every access through a req/gnt issue phase and an rvalid response phase.

## Interface
- `XLEN`, 32: address/data width.
- `STARVE_MAX`, 4: consecutive data wins tolerated while a fetch is pending; legal range 1..15.

Ports:
- `i_arb_clk` in 1: clock.
- `i_arb_rst` in 1: reset, synchronous, active-high.
- `i_arb_i_req` in 1: fetch request; held until `o_arb_i_gnt`.
- `i_arb_i_addr` in XLEN: fetch address.
- `o_arb_i_gnt` out 1: fetch accepted by memory (1-cycle pulse).
- `o_arb_i_rvalid` out 1: fetch data valid (1-cycle pulse).
- `o_arb_i_rdata` out 32: fetch data.
- `i_arb_d_req` in 1: data request; held until `o_arb_d_gnt`.
- `i_arb_d_we` in 1: 1 = store, 0 = load.
- `i_arb_d_addr` in XLEN: data address.
- `i_arb_d_wdata` in XLEN: store data.
- `i_arb_d_bytectrl` in 3: access-size code, passed through unchanged.
- `o_arb_d_gnt` out 1: data request accepted (1-cycle pulse).
- `o_arb_d_rvalid` out 1: load data valid / store acknowledged (1-cycle pulse).
- `o_arb_d_rdata` out XLEN: load data.
- `o_arb_m_req` out 1: memory request.
- `o_arb_m_we` out 1: memory write enable.
- `o_arb_m_addr` out XLEN: memory address.
- `o_arb_m_wdata` out XLEN: memory write data.
- `o_arb_m_bytectrl` out 3: memory size code; fetches always issue 3'b010 (word).
- `i_arb_m_gnt` in 1: memory accepted the current request.
- `i_arb_m_rvalid` in 1: memory response valid.
- `i_arb_m_rdata` in XLEN: memory response data.

## Operation
- The FSM has three states: IDLE, ISSUE and WAIT. It also keeps a 1-bit owner register (0 = I, 1 = D) and a 4-bit starvation counter `starve`.
- Arbitration happens in IDLE, or in WAIT on the response cycle. It runs only when at least one request is asserted:
  - The winner is I if `i_arb_i_req && (!i_arb_d_req || starve == STARVE_MAX)`.
  - Otherwise the winner is D.
  - The winner's addr, we, wdata and bytectrl are latched into the `o_arb_m_*` registers and the owner is recorded.
  - The next state is ISSUE.
- Starvation counter update at each arbitration:
  - D wins while `i_arb_i_req` is high: `starve` increments, saturating at STARVE_MAX.
  - I wins: `starve` is cleared to 0.
  - D wins with no fetch pending: `starve` holds its value.
- ISSUE:
  - `o_arb_m_req` = 1 and the latched fields are held stable.
  - On `i_arb_m_gnt`: the owner's `o_arb_x_gnt` pulses combinationally in the same cycle, `o_arb_m_req` drops next cycle, and the FSM moves to WAIT.
- WAIT:
  - On `i_arb_m_rvalid`, the owner's `o_arb_x_rvalid` pulses combinationally and the other requester's rvalid stays 0.
  - Stores also receive rvalid, as a write acknowledge.
  - In the same cycle the FSM re-arbitrates: if any request is pending it goes to ISSUE, otherwise to IDLE.
- `o_arb_i_rdata` and `o_arb_d_rdata` are direct wires from `i_arb_m_rdata`; they are meaningful only while the matching rvalid is high.
- Ignored inputs:
  - `i_arb_m_rvalid` in IDLE or ISSUE.
  - `i_arb_m_gnt` outside ISSUE.
  - Requests in ISSUE or in WAIT before rvalid.
- Reset:
  - State goes to IDLE, `starve` to 0, owner to 0.
  - All `o_arb_m_*` registers go to 0, and every gnt and rvalid output is 0.
  - Reset asserted mid-transaction abandons it. A response that arrives after reset lands in IDLE and is dropped.

## Timing
- From a request in cycle N (FSM in IDLE), `o_arb_m_req` is high in cycle N+1.
- With memory granting in N+1, the earliest rvalid is in N+2. The next transaction's `o_arb_m_req` is then high in N+3 (back-to-back, no IDLE bubble).
- The grant pulse is exactly coincident with `i_arb_m_gnt`. The rvalid pulse is exactly coincident with `i_arb_m_rvalid`. Neither pulse lasts more than one cycle per transaction.
- Memory stall: while `i_arb_m_gnt` = 0 in ISSUE, `o_arb_m_req` and all fields remain constant indefinitely.
- Every `o_arb_m_*` output is a flop output. The only combinational paths are gnt and rvalid, which are decoded from owner and state.

## Test plan
- **Single fetch:** `i_req` = 1 with addr 0x100, memory grants immediately and returns 0xDEADBEEF two cycles later.
  - Required: `m_req` in cycle 1 with addr 0x100 and bytectrl 3'b010, `i_gnt` in cycle 1, `i_rvalid` with rdata 0xDEADBEEF, `d_rvalid` = 0 throughout.
- **Collision:** `i_req` and `d_req` (store, addr 0x2000, wdata 0x55) asserted in the same cycle.
  - Required: D is issued first with `m_we` = 1 and wdata 0x55, and the fetch issues in the cycle immediately after D's rvalid.
- **Starvation, STARVE_MAX = 4:** `d_req` held high continuously alongside `i_req`.
  - Required: exactly 4 D transactions, then one I transaction, then `starve` = 0 and D resumes.
- **Memory backpressure:** `i_arb_m_gnt` held low for 5 cycles in ISSUE.
  - Required: `m_req`, addr and wdata are unchanged for all 5 cycles, and exactly one gnt pulse occurs.
- **Spurious responses:** `i_arb_m_rvalid` pulsed in IDLE, and `i_arb_m_gnt` pulsed in WAIT.
  - Required: no gnt or rvalid output and no state change.
- **Reset mid-WAIT:** `i_arb_rst` asserted for 1 cycle, then memory returns a stale rvalid.
  - Required: all outputs 0 the cycle after reset, the stale rvalid is dropped, and a subsequent fetch completes normally.

Source files
------------

// File: rtl/rv_mem_arbiter_if.sv
// Bus bundle between the core's fetch/data ports, the arbiter and the unified memory.
// The slave modport is the arbiter's view; master is the core plus memory side.
interface rv_mem_arbiter_if #(
    parameter int unsigned XLEN = 32
);
    // Instruction-fetch requester
    logic            i_arb_i_req;
    logic [XLEN-1:0] i_arb_i_addr;
    logic            o_arb_i_gnt;
    logic            o_arb_i_rvalid;
    logic [XLEN-1:0] o_arb_i_rdata;

    // Data requester
    logic            i_arb_d_req;
    logic            i_arb_d_we;
    logic [XLEN-1:0] i_arb_d_addr;
    logic [XLEN-1:0] i_arb_d_wdata;
    logic [2:0]      i_arb_d_bytectrl;
    logic            o_arb_d_gnt;
    logic            o_arb_d_rvalid;
    logic [XLEN-1:0] o_arb_d_rdata;

    // Memory side
    logic            o_arb_m_req;
    logic            o_arb_m_we;
    logic [XLEN-1:0] o_arb_m_addr;
    logic [XLEN-1:0] o_arb_m_wdata;
    logic [2:0]      o_arb_m_bytectrl;
    logic            i_arb_m_gnt;
    logic            i_arb_m_rvalid;
    logic [XLEN-1:0] i_arb_m_rdata;

    modport slave (
        input  i_arb_i_req,
        input  i_arb_i_addr,
        output o_arb_i_gnt,
        output o_arb_i_rvalid,
        output o_arb_i_rdata,
        input  i_arb_d_req,
        input  i_arb_d_we,
        input  i_arb_d_addr,
        input  i_arb_d_wdata,
        input  i_arb_d_bytectrl,
        output o_arb_d_gnt,
        output o_arb_d_rvalid,
        output o_arb_d_rdata,
        output o_arb_m_req,
        output o_arb_m_we,
        output o_arb_m_addr,
        output o_arb_m_wdata,
        output o_arb_m_bytectrl,
        input  i_arb_m_gnt,
        input  i_arb_m_rvalid,
        input  i_arb_m_rdata
    );

    modport master (
        output i_arb_i_req,
        output i_arb_i_addr,
        input  o_arb_i_gnt,
        input  o_arb_i_rvalid,
        input  o_arb_i_rdata,
        output i_arb_d_req,
        output i_arb_d_we,
        output i_arb_d_addr,
        output i_arb_d_wdata,
        output i_arb_d_bytectrl,
        input  o_arb_d_gnt,
        input  o_arb_d_rvalid,
        input  o_arb_d_rdata,
        input  o_arb_m_req,
        input  o_arb_m_we,
        input  o_arb_m_addr,
        input  o_arb_m_wdata,
        input  o_arb_m_bytectrl,
        output i_arb_m_gnt,
        output i_arb_m_rvalid,
        output i_arb_m_rdata
    );
endinterface

// File: rtl/rv_mem_arbiter.sv
// Fetch/data arbiter onto one single-port memory, one transaction outstanding.
// Data has fixed priority; a starvation counter forces a fetch through after STARVE_MAX data wins.
module rv_mem_arbiter #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input logic              i_arb_clk,
    input logic              i_arb_rst,
    rv_mem_arbiter_if.slave  arb
);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait
    } state_e;

    localparam logic       OwnerI    = 1'b0;
    localparam logic       OwnerD    = 1'b1;
    localparam logic [2:0] WordSize  = 3'b010;
    localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

    state_e          state_q, state_d;
    logic            owner_q, owner_d;
    logic [3:0]      starve_q, starve_d;
    logic            m_req_q, m_req_d;
    logic            m_we_q, m_we_d;
    logic [XLEN-1:0] m_addr_q, m_addr_d;
    logic [XLEN-1:0] m_wdata_q, m_wdata_d;
    logic [2:0]      m_bytectrl_q, m_bytectrl_d;

    logic any_req;
    logic win_i;
    logic arb_en;

    assign any_req = arb.i_arb_i_req | arb.i_arb_d_req;
    assign win_i   = arb.i_arb_i_req & (~arb.i_arb_d_req | (starve_q == StarveMax));

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        starve_d     = starve_q;
        m_req_d      = m_req_q;
        m_we_d       = m_we_q;
        m_addr_d     = m_addr_q;
        m_wdata_d    = m_wdata_q;
        m_bytectrl_d = m_bytectrl_q;
        arb_en       = 1'b0;

        unique case (state_q)
            StIdle: begin
                arb_en = 1'b1;
            end
            StIssue: begin
                if (arb.i_arb_m_gnt) begin
                    state_d = StWait;
                    m_req_d = 1'b0;
                end
            end
            StWait: begin
                // Response cycle doubles as the next arbitration slot: no idle bubble.
                if (arb.i_arb_m_rvalid) begin
                    state_d = StIdle;
                    arb_en  = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                m_req_d = 1'b0;
            end
        endcase

        if (arb_en && any_req) begin
            state_d = StIssue;
            m_req_d = 1'b1;
            if (win_i) begin
                owner_d      = OwnerI;
                starve_d     = 4'd0;
                m_we_d       = 1'b0;
                m_addr_d     = arb.i_arb_i_addr;
                m_wdata_d    = '0;
                m_bytectrl_d = WordSize;
            end else begin
                owner_d      = OwnerD;
                m_we_d       = arb.i_arb_d_we;
                m_addr_d     = arb.i_arb_d_addr;
                m_wdata_d    = arb.i_arb_d_wdata;
                m_bytectrl_d = arb.i_arb_d_bytectrl;
                // Only a data win over a waiting fetch counts toward starvation.
                if (arb.i_arb_i_req && (starve_q != StarveMax)) begin
                    starve_d = starve_q + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge i_arb_clk) begin
        if (i_arb_rst) begin
            state_q      <= StIdle;
            owner_q      <= OwnerI;
            starve_q     <= 4'd0;
            m_req_q      <= 1'b0;
            m_we_q       <= 1'b0;
            m_addr_q     <= '0;
            m_wdata_q    <= '0;
            m_bytectrl_q <= 3'b000;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            starve_q     <= starve_d;
            m_req_q      <= m_req_d;
            m_we_q       <= m_we_d;
            m_addr_q     <= m_addr_d;
            m_wdata_q    <= m_wdata_d;
            m_bytectrl_q <= m_bytectrl_d;
        end
    end

    assign arb.o_arb_m_req      = m_req_q;
    assign arb.o_arb_m_we       = m_we_q;
    assign arb.o_arb_m_addr     = m_addr_q;
    assign arb.o_arb_m_wdata    = m_wdata_q;
    assign arb.o_arb_m_bytectrl = m_bytectrl_q;

    // Handshake pulses are decoded from state and owner, coincident with the memory strobes.
    assign arb.o_arb_i_gnt    = (state_q == StIssue) & arb.i_arb_m_gnt & (owner_q == OwnerI);
    assign arb.o_arb_d_gnt    = (state_q == StIssue) & arb.i_arb_m_gnt & (owner_q == OwnerD);
    assign arb.o_arb_i_rvalid = (state_q == StWait) & arb.i_arb_m_rvalid & (owner_q == OwnerI);
    assign arb.o_arb_d_rvalid = (state_q == StWait) & arb.i_arb_m_rvalid & (owner_q == OwnerD);

    assign arb.o_arb_i_rdata = arb.i_arb_m_rdata;
    assign arb.o_arb_d_rdata = arb.i_arb_m_rdata;

endmodule

// File: tb/tb_rv_mem_arbiter.sv
// Directed and randomized bench for rv_mem_arbiter against a transaction-level model.
module tb_rv_mem_arbiter;

    localparam int StarveLimit = 4;

    logic clk;
    logic rst;

    rv_mem_arbiter_if #(.XLEN(32)) arb_bus ();

    rv_mem_arbiter #(
        .XLEN       (32),
        .STARVE_MAX (StarveLimit)
    ) dut (
        .i_arb_clk (clk),
        .i_arb_rst (rst),
        .arb       (arb_bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: the one outstanding transaction and the fairness tally.
    bit          busy, granted, own_d;
    int          starve;
    logic        lat_we;
    logic [31:0] lat_addr, lat_wdata;
    logic [2:0]  lat_bc;

    // Requester agents
    bit          i_pend, d_pend, d_auto, d_we;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic [2:0]  d_bc;

    int gnt_log[$];
    int i_rv_cnt = 0;
    int d_rv_cnt = 0;

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic new_d();
        d_pend  = 1'b1;
        d_we    = 1'($urandom % 2);
        d_addr  = $urandom & 32'hffff_fffc;
        d_wdata = $urandom;
        d_bc    = 3'($urandom % 8);
    endtask

    // One clock: drive, check at the falling edge, advance the model.
    task automatic tick(input bit mg, input bit mr, input logic [31:0] rd, input bit r);
        bit e_req, e_ig, e_dg, e_ir, e_dr, slot, pick_i;
        rst                       = r;
        arb_bus.i_arb_i_req       = i_pend;
        arb_bus.i_arb_i_addr      = i_addr;
        arb_bus.i_arb_d_req       = d_pend;
        arb_bus.i_arb_d_we        = d_we;
        arb_bus.i_arb_d_addr      = d_addr;
        arb_bus.i_arb_d_wdata     = d_wdata;
        arb_bus.i_arb_d_bytectrl  = d_bc;
        arb_bus.i_arb_m_gnt       = mg;
        arb_bus.i_arb_m_rvalid    = mr;
        arb_bus.i_arb_m_rdata     = rd;
        @(negedge clk);
        e_req = busy && !granted;
        e_ig  = busy && !granted && mg && !own_d;
        e_dg  = busy && !granted && mg && own_d;
        e_ir  = busy && granted && mr && !own_d;
        e_dr  = busy && granted && mr && own_d;
        if (!r) begin
            chk1("m_req", arb_bus.o_arb_m_req, e_req);
            chk1("m_we", arb_bus.o_arb_m_we, lat_we);
            chk32("m_addr", arb_bus.o_arb_m_addr, lat_addr);
            chk32("m_wdata", arb_bus.o_arb_m_wdata, lat_wdata);
            chk32("m_bytectrl", {29'b0, arb_bus.o_arb_m_bytectrl}, {29'b0, lat_bc});
            chk1("i_gnt", arb_bus.o_arb_i_gnt, e_ig);
            chk1("d_gnt", arb_bus.o_arb_d_gnt, e_dg);
            chk1("i_rvalid", arb_bus.o_arb_i_rvalid, e_ir);
            chk1("d_rvalid", arb_bus.o_arb_d_rvalid, e_dr);
            if (e_ir) chk32("i_rdata", arb_bus.o_arb_i_rdata, rd);
            if (e_dr) chk32("d_rdata", arb_bus.o_arb_d_rdata, rd);
        end
        if (arb_bus.o_arb_i_gnt === 1'b1) gnt_log.push_back(0);
        if (arb_bus.o_arb_d_gnt === 1'b1) gnt_log.push_back(1);
        if (arb_bus.o_arb_i_rvalid === 1'b1) i_rv_cnt++;
        if (arb_bus.o_arb_d_rvalid === 1'b1) d_rv_cnt++;

        if (r) begin
            busy = 0; granted = 0; own_d = 0; starve = 0;
            lat_we = 0; lat_addr = '0; lat_wdata = '0; lat_bc = '0;
        end else begin
            slot = !busy || (granted && mr);
            if (slot && (i_pend || d_pend)) begin
                pick_i = i_pend && (!d_pend || starve == StarveLimit);
                busy = 1; granted = 0; own_d = !pick_i;
                if (pick_i) begin
                    starve = 0;
                    lat_we = 0; lat_addr = i_addr; lat_wdata = '0; lat_bc = 3'b010;
                end else begin
                    if (i_pend) starve = (starve < StarveLimit) ? starve + 1 : StarveLimit;
                    lat_we = d_we; lat_addr = d_addr; lat_wdata = d_wdata; lat_bc = d_bc;
                end
            end else if (slot) begin
                busy = 0;
            end else if (!granted && mg) begin
                granted = 1;
            end
        end
        if (e_ig) i_pend = 0;
        if (e_dg) begin
            d_pend = 0;
            if (d_auto) new_d();
        end
        @(posedge clk);
        #1;
    endtask

    int n0, rv0;
    int exp_pat[6];

    initial begin
        exp_pat = '{1, 1, 1, 1, 0, 1};
        rst = 1'b1;
        i_pend = 0; d_pend = 0; d_auto = 0; d_we = 0;
        i_addr = '0; d_addr = '0; d_wdata = '0; d_bc = '0;
        busy = 0; granted = 0; own_d = 0; starve = 0;
        lat_we = 0; lat_addr = '0; lat_wdata = '0; lat_bc = '0;

        // Reset, then quiet cycles must show all-zero outputs.
        tick(0, 0, 32'h0, 1);
        tick(0, 0, 32'h0, 1);
        tick(0, 0, 32'h0, 0);
        tick(0, 1, 32'h1234_5678, 0);

        // Single fetch
        i_pend = 1; i_addr = 32'h100;
        tick(0, 0, 32'h0, 0);
        tick(1, 0, 32'h0, 0);
        tick(0, 0, 32'h0, 0);
        tick(0, 1, 32'hDEAD_BEEF, 0);
        tick(0, 0, 32'h0, 0);
        chk32("fetch_rvalids", 32'(i_rv_cnt), 32'd1);
        chk32("fetch_d_rvalids", 32'(d_rv_cnt), 32'd0);

        // Collision: data store first, fetch immediately after its response
        n0 = gnt_log.size();
        i_pend = 1; i_addr = 32'h800;
        d_pend = 1; d_we = 1; d_addr = 32'h2000; d_wdata = 32'h55; d_bc = 3'b010;
        for (int k = 0; k < 6; k++) tick(1, 1, $urandom, 0);
        chk32("collide_cnt", 32'(gnt_log.size() - n0), 32'd2);
        if (gnt_log.size() - n0 >= 2) begin
            chk32("collide_first", 32'(gnt_log[n0]), 32'd1);
            chk32("collide_second", 32'(gnt_log[n0+1]), 32'd0);
        end

        // Starvation: continuous data traffic alongside one fetch
        n0 = gnt_log.size();
        i_pend = 1; i_addr = 32'h700;
        d_auto = 1; new_d();
        for (int k = 0; k < 100 && (gnt_log.size() - n0) < 6; k++) tick(1, 1, $urandom, 0);
        d_auto = 0;
        for (int k = 0; k < 10; k++) tick(1, 1, $urandom, 0);
        chk1("starve_reached", (gnt_log.size() - n0) >= 6, 1'b1);
        if ((gnt_log.size() - n0) >= 6) begin
            for (int k = 0; k < 6; k++) chk32("starve_order", 32'(gnt_log[n0+k]), 32'(exp_pat[k]));
        end

        // Memory backpressure: five cycles without grant
        n0 = gnt_log.size();
        d_pend = 1; d_we = 1; d_addr = 32'h3000; d_wdata = $urandom; d_bc = 3'b001;
        tick(0, 0, 32'h0, 0);
        for (int k = 0; k < 5; k++) tick(0, 0, 32'h0, 0);
        tick(1, 0, 32'h0, 0);
        tick(0, 1, 32'h0, 0);
        chk32("bp_gnts", 32'(gnt_log.size() - n0), 32'd1);

        // Spurious strobes: rvalid in IDLE, gnt in WAIT
        n0 = gnt_log.size();
        rv0 = i_rv_cnt + d_rv_cnt;
        tick(0, 1, $urandom, 0);
        i_pend = 1; i_addr = 32'h400;
        tick(0, 0, 32'h0, 0);
        tick(1, 0, 32'h0, 0);
        tick(1, 0, 32'h0, 0);
        tick(1, 0, 32'h0, 0);
        tick(0, 1, 32'hCAFE_F00D, 0);
        chk32("spur_gnts", 32'(gnt_log.size() - n0), 32'd1);
        chk32("spur_rvalids", 32'(i_rv_cnt + d_rv_cnt - rv0), 32'd1);

        // Reset mid-WAIT, stale response dropped, next fetch completes
        rv0 = i_rv_cnt;
        i_pend = 1; i_addr = 32'h500;
        tick(0, 0, 32'h0, 0);
        tick(1, 0, 32'h0, 0);
        tick(0, 0, 32'h0, 0);
        tick(0, 0, 32'h0, 1);
        tick(0, 1, 32'hBAD0_BAD0, 0);
        chk32("stale_dropped", 32'(i_rv_cnt - rv0), 32'd0);
        i_pend = 1; i_addr = 32'h600;
        tick(0, 0, 32'h0, 0);
        tick(1, 0, 32'h0, 0);
        tick(0, 1, 32'h600D_600D, 0);
        chk32("post_reset_fetch", 32'(i_rv_cnt - rv0), 32'd1);

        // Randomized traffic and memory timing
        for (int k = 0; k < 400; k++) begin
            if (!i_pend && ($urandom % 4) == 0) begin
                i_pend = 1;
                i_addr = $urandom & 32'hffff_fffc;
            end
            if (!d_pend && ($urandom % 4) == 0) new_d();
            tick(1'($urandom % 2), 1'($urandom % 2), $urandom, 0);
        end
        for (int k = 0; k < 12; k++) tick(1, 1, $urandom, 0);
        chk1("drained", busy || i_pend || d_pend, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
